// File: rtl/pwm_duty_keypad.sv
// Purpose : debounced increase/decrease buttons driving a saturating 4-bit duty register (tenths).
// Latency : raw edge -> accepted level in 2+(DEBOUNCE_TICKS-1)*TICK_DIV+1 .. 2+DEBOUNCE_TICKS*TICK_DIV cycles, duty one cycle later.
// Backpress: none; buttons are sampled continuously and duty/duty_changed are always valid.
// Optional hold-to-repeat stepping is compiled in when PWM_DUTY_REPEAT_EN is defined.
module pwm_duty_keypad #(
    parameter int TICK_DIV       = 4,
    parameter int DEBOUNCE_TICKS = 3,
    parameter int DUTY_MAX       = 10,
    parameter int DUTY_RESET     = 5,
    parameter int REPEAT_DELAY   = 8,
    parameter int REPEAT_RATE    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic [3:0] duty,
    output logic       duty_changed,
    output logic       inc_db,
    output logic       dec_db
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (DEBOUNCE_TICKS > 0) ? $clog2(DEBOUNCE_TICKS + 1) : 1;

    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_TICKS - 1);
    localparam logic [3:0]    DMAX       = 4'(DUTY_MAX);
    localparam logic [3:0]    DRESET     = 4'(DUTY_RESET);

    // Reject parameter sets the datapath cannot represent.
    if (TICK_DIV < 2 || DEBOUNCE_TICKS < 1 || DUTY_MAX > 15 || DUTY_RESET > DUTY_MAX ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("pwm_duty_keypad: illegal parameter combination");
    end

    // Index 0 is the increase button, index 1 the decrease button.
    logic [1:0] btn_raw;
    logic [1:0] stable;
    logic [1:0] stable_q;
    logic [1:0] edge_req;
    logic [1:0] rpt_req;

    logic [TW-1:0] tick_cnt;
    logic          tick;

    logic [3:0] duty_next;
    logic       inc_step;
    logic       dec_step;

    assign btn_raw = {btn_dec, btn_inc};
    assign tick    = (tick_cnt == TICK_LAST);

    // Free-running debounce sample prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_btn
        logic          sync1;
        logic          sync2;
        logic          lvl;
        logic [CW-1:0] cnt;

        // Two-flop synchroniser for the asynchronous button.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
            end else begin
                sync1 <= btn_raw[g];
                sync2 <= sync1;
            end
        end

        // Accept a new level only after it persists for DEBOUNCE_TICKS consecutive ticks.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lvl <= 1'b0;
                cnt <= '0;
            end else if (tick) begin
                if (sync2 != lvl) begin
                    if (cnt == DB_LAST) begin
                        lvl <= ~lvl;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end

        assign stable[g] = lvl;

`ifdef PWM_DUTY_REPEAT_EN
        localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
        localparam int RW   = $clog2(RMAX + 1);
        localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
        localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

        logic [RW-1:0] rcnt;
        logic          armed;
        logic          rreq;
        logic          hold_ok;

        // Only a lone held button auto-repeats; pressing both cancels it.
        assign hold_ok = lvl & ~stable[1-g];

        // Hold timer: first repeat after REPEAT_DELAY ticks, then every REPEAT_RATE ticks.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rcnt  <= '0;
                armed <= 1'b0;
                rreq  <= 1'b0;
            end else begin
                rreq <= 1'b0;
                if (!hold_ok) begin
                    rcnt  <= '0;
                    armed <= 1'b0;
                end else if (tick) begin
                    if (rcnt == (armed ? RATE_LAST : DELAY_LAST)) begin
                        rcnt  <= '0;
                        armed <= 1'b1;
                        rreq  <= 1'b1;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
            end
        end

        assign rpt_req[g] = rreq;
`else
        assign rpt_req[g] = 1'b0;
`endif
    end

    // Delayed copy of the debounced levels for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= 2'b00;
        end else begin
            stable_q <= stable;
        end
    end

    assign edge_req = stable & ~stable_q;
    assign inc_step = edge_req[0] | rpt_req[0];
    assign dec_step = edge_req[1] | rpt_req[1];
    assign inc_db   = stable[0];
    assign dec_db   = stable[1];

    // Saturating step; opposing requests in the same cycle cancel.
    always_comb begin
        duty_next = duty;
        if (inc_step && !dec_step) begin
            if (duty < DMAX) begin
                duty_next = duty + 4'd1;
            end
        end else if (dec_step && !inc_step) begin
            if (duty != 4'd0) begin
                duty_next = duty - 4'd1;
            end
        end
    end

    // Duty register and its change strobe, aligned with the first cycle of a new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty         <= DRESET;
            duty_changed <= 1'b0;
        end else begin
            duty         <= duty_next;
            duty_changed <= (duty_next != duty);
        end
    end

endmodule

// File: tb/tb_pwm_duty_keypad.sv
// Directed bench for pwm_duty_keypad with TICK_DIV=4, DEBOUNCE_TICKS=3, DUTY_MAX=10, DUTY_RESET=5.
// Inputs change 1 time unit after a rising edge; outputs are read at that same point.
// Strobe and debounced-level activity is tallied on falling edges.
module tb_pwm_duty_keypad;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic [3:0] duty;
    logic       duty_changed;
    logic       inc_db;
    logic       dec_db;

    int checks = 0;
    int passed = 0;
    int strobes = 0;
    int dec_hi = 0;

`ifdef PWM_DUTY_REPEAT_EN
    localparam int HOLD = 25;
`else
    localparam int HOLD = 40;
`endif

    pwm_duty_keypad #(
        .TICK_DIV(4), .DEBOUNCE_TICKS(3), .DUTY_MAX(10), .DUTY_RESET(5),
        .REPEAT_DELAY(8), .REPEAT_RATE(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .duty(duty), .duty_changed(duty_changed), .inc_db(inc_db), .dec_db(dec_db)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (duty_changed === 1'b1) strobes++;
        if (dec_db === 1'b1) dec_hi++;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_btn(input bit inc);
        if (inc) btn_inc = 1'b1; else btn_dec = 1'b1;
        cyc(20);
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        cyc(20);
    endtask

    task automatic test_reset();
        int s0;
        rst_n = 1'b0;
        cyc(3);
        checks++; if (duty !== 4'd5) $display("FAIL reset_duty: got %0d want 5", duty); else passed++;
        checks++; if (duty_changed !== 1'b0) $display("FAIL reset_strobe: got %b want 0", duty_changed); else passed++;
        checks++; if ({inc_db, dec_db} !== 2'b00) $display("FAIL reset_db: got %b want 00", {inc_db, dec_db}); else passed++;
        rst_n = 1'b1;
        s0 = strobes;
        cyc(50);
        checks++; if (duty !== 4'd5) $display("FAIL idle_duty: got %0d want 5", duty); else passed++;
        checks++; if (strobes - s0 !== 0) $display("FAIL idle_strobes: got %0d want 0", strobes - s0); else passed++;
        checks++; if ({inc_db, dec_db} !== 2'b00) $display("FAIL idle_db: got %b want 00", {inc_db, dec_db}); else passed++;
    endtask

    task automatic test_inc_press();
        int s0;
        int n;
        s0 = strobes;
        n = 0;
        btn_inc = 1'b1;
        while (inc_db !== 1'b1 && n < 30) begin
            cyc(1);
            n++;
        end
        checks++; if (n < 11 || n > 14) $display("FAIL inc_accept_latency: got %0d want 11..14", n); else passed++;
        checks++; if (duty !== 4'd5) $display("FAIL inc_request_cycle_duty: got %0d want 5", duty); else passed++;
        cyc(1);
        checks++; if (duty !== 4'd6) $display("FAIL inc_step_duty: got %0d want 6", duty); else passed++;
        checks++; if (duty_changed !== 1'b1) $display("FAIL inc_step_strobe: got %b want 1", duty_changed); else passed++;
        cyc(1);
        checks++; if (duty_changed !== 1'b0) $display("FAIL inc_strobe_width: got %b want 0", duty_changed); else passed++;
        cyc(HOLD - n - 2);
        checks++; if (duty !== 4'd6) $display("FAIL inc_hold_duty: got %0d want 6", duty); else passed++;
        checks++; if (strobes - s0 !== 1) $display("FAIL inc_hold_strobes: got %0d want 1", strobes - s0); else passed++;
        btn_inc = 1'b0;
        cyc(20);
        checks++; if (inc_db !== 1'b0) $display("FAIL inc_release_db: got %b want 0", inc_db); else passed++;
        checks++; if (duty !== 4'd6) $display("FAIL inc_release_duty: got %0d want 6", duty); else passed++;
        checks++; if (strobes - s0 !== 1) $display("FAIL inc_release_strobes: got %0d want 1", strobes - s0); else passed++;
    endtask

    task automatic test_glitch();
        int s0;
        int h0;
        s0 = strobes;
        h0 = dec_hi;
        btn_dec = 1'b1;
        cyc(3);
        btn_dec = 1'b0;
        cyc(30);
        checks++; if (dec_hi - h0 !== 0) $display("FAIL glitch_dec_db: high for %0d cycles want 0", dec_hi - h0); else passed++;
        checks++; if (duty !== 4'd6) $display("FAIL glitch_duty: got %0d want 6", duty); else passed++;
        checks++; if (strobes - s0 !== 0) $display("FAIL glitch_strobes: got %0d want 0", strobes - s0); else passed++;
    endtask

    task automatic test_saturation();
        int s0;
        int expd;
        int prev;
        expd = 6;
        for (int k = 1; k <= 7; k++) begin
            prev = expd;
            expd = (prev < 10) ? prev + 1 : 10;
            s0 = strobes;
            press_btn(1'b1);
            checks++; if (duty !== 4'(expd)) $display("FAIL inc_press%0d_duty: got %0d want %0d", k, duty, expd); else passed++;
            checks++; if (strobes - s0 !== ((prev < 10) ? 1 : 0)) $display("FAIL inc_press%0d_strobes: got %0d want %0d", k, strobes - s0, (prev < 10) ? 1 : 0); else passed++;
        end
        for (int k = 1; k <= 11; k++) begin
            prev = expd;
            expd = (prev > 0) ? prev - 1 : 0;
            s0 = strobes;
            press_btn(1'b0);
            checks++; if (duty !== 4'(expd)) $display("FAIL dec_press%0d_duty: got %0d want %0d", k, duty, expd); else passed++;
            checks++; if (strobes - s0 !== ((prev > 0) ? 1 : 0)) $display("FAIL dec_press%0d_strobes: got %0d want %0d", k, strobes - s0, (prev > 0) ? 1 : 0); else passed++;
        end
    endtask

    task automatic test_simultaneous();
        int s0;
        int n;
        press_btn(1'b1);
        press_btn(1'b1);
        checks++; if (duty !== 4'd2) $display("FAIL simul_setup_duty: got %0d want 2", duty); else passed++;
        s0 = strobes;
        n = 0;
        btn_inc = 1'b1;
        btn_dec = 1'b1;
        while (inc_db !== 1'b1 && dec_db !== 1'b1 && n < 30) begin
            cyc(1);
            n++;
        end
        checks++; if (n >= 30) $display("FAIL simul_accept_timeout: waited %0d cycles want <30", n); else passed++;
        checks++; if ({inc_db, dec_db} !== 2'b11) $display("FAIL simul_db_together: got %b want 11", {inc_db, dec_db}); else passed++;
        cyc(10);
        checks++; if (duty !== 4'd2) $display("FAIL simul_duty: got %0d want 2", duty); else passed++;
        checks++; if (strobes - s0 !== 0) $display("FAIL simul_strobes: got %0d want 0", strobes - s0); else passed++;
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        cyc(20);
        checks++; if (duty !== 4'd2) $display("FAIL simul_release_duty: got %0d want 2", duty); else passed++;
        checks++; if (strobes - s0 !== 0) $display("FAIL simul_release_strobes: got %0d want 0", strobes - s0); else passed++;
    endtask

`ifdef PWM_DUTY_REPEAT_EN
    task automatic test_repeat();
        int t[$];
        int s0;
        int n;
        // Hold decrease long enough to walk 2 -> 1 -> 0.
        btn_dec = 1'b1;
        cyc(80);
        btn_dec = 1'b0;
        cyc(20);
        checks++; if (duty !== 4'd0) $display("FAIL rpt_setup_duty: got %0d want 0", duty); else passed++;
        s0 = strobes;
        btn_inc = 1'b1;
        for (int c = 0; c < 200; c++) begin
            cyc(1);
            if (duty_changed === 1'b1) t.push_back(c);
        end
        checks++; if (t.size() !== 10) $display("FAIL rpt_step_count: got %0d want 10", t.size()); else passed++;
        if (t.size() >= 3) begin
            checks++; if (t[1] - t[0] !== 32) $display("FAIL rpt_first_gap: got %0d want 32", t[1] - t[0]); else passed++;
            checks++; if (t[2] - t[1] !== 8) $display("FAIL rpt_rate_gap: got %0d want 8", t[2] - t[1]); else passed++;
        end else begin
            checks++; $display("FAIL rpt_gaps: only %0d steps seen want >=3", t.size());
        end
        checks++; if (duty !== 4'd10) $display("FAIL rpt_sat_duty: got %0d want 10", duty); else passed++;
        checks++; if (strobes - s0 !== 10) $display("FAIL rpt_sat_strobes: got %0d want 10", strobes - s0); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if (duty !== 4'd5) $display("FAIL rpt_async_reset_duty: got %0d want 5", duty); else passed++;
        cyc(1);
        rst_n = 1'b1;
        n = 0;
        while (duty_changed !== 1'b1 && n < 40) begin
            cyc(1);
            n++;
        end
        checks++; if (n < 12 || n > 15) $display("FAIL rpt_redebounce_latency: got %0d want 12..15", n); else passed++;
        checks++; if (duty !== 4'd6) $display("FAIL rpt_after_reset_duty: got %0d want 6", duty); else passed++;
        btn_inc = 1'b0;
        cyc(20);
    endtask
`endif

    initial begin
        test_reset();
        test_inc_press();
        test_glitch();
        test_saturation();
        test_simultaneous();
`ifdef PWM_DUTY_REPEAT_EN
        test_repeat();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
